// File: rtl/cdc_pkg.sv
// Shared types and constants for the clock-domain-crossing handshake blocks.
`default_nettype none

package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } hs_tx_state_t;

  localparam int CDC_SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/cdc_2ff_sync.sv
// Multi-flop resynchroniser for a signal arriving from a foreign clock domain.
`default_nettype none

module cdc_2ff_sync
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] stage [CDC_SYNC_STAGES];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < CDC_SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d_i;
      for (int i = 1; i < CDC_SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q_o = stage[CDC_SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cdc_hs_tx.sv
// Source side of a 2-phase toggle req/ack handshake carrying one word per
// transfer into a foreign clock domain, with timeout and protocol-error flags.
`default_nettype none

module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic                  proto_err_o,
  input  logic                  err_clr_i
);

  hs_tx_state_t state;
  hs_tx_state_t state_nxt;

  logic ack_s;
  logic ack_prev;
  logic ack_match;
  logic accept;
  logic proto_set;

  cdc_2ff_sync #(
    .DATA_WIDTH (1)
  ) u_ack_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d_i    (ack_i),
    .q_o    (ack_s)
  );

  // A transfer is outstanding whenever req and the synchronised ack differ.
  assign ack_match  = (ack_s == req_o);
  assign in_ready_o = (state == IDLE) && ack_match;
  assign busy_o     = (state == WAIT_ACK);
  assign accept     = in_valid_i && in_ready_o;
  assign proto_set  = (state == IDLE) && (ack_s != ack_prev);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept)    state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_match) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      req_o    <= 1'b0;
      data_o   <= '0;
      ack_prev <= 1'b0;
    end else begin
      ack_prev <= ack_s;
      if (accept) begin
        req_o  <= ~req_o;
        data_o <= in_data_i;
      end
    end
  end

  // Sticky flags: a new set event takes priority over a clear request.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      proto_err_o <= 1'b0;
    end else if (proto_set) begin
      proto_err_o <= 1'b1;
    end else if (err_clr_i) begin
      proto_err_o <= 1'b0;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

      logic [CNT_WIDTH-1:0] cnt;

      // Counter saturates at all-ones so the flag fires once per transfer.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          cnt       <= '0;
          timeout_o <= 1'b0;
        end else begin
          if (accept) begin
            cnt <= '0;
          end else if (busy_o && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
          end

          if (busy_o && !ack_match && (cnt == LAST)) begin
            timeout_o <= 1'b1;
          end else if (err_clr_i) begin
            timeout_o <= 1'b0;
          end
        end
      end
    end else begin : g_no_timeout
      assign timeout_o = 1'b0;
    end
  endgenerate

  generate
    if (TIMEOUT_CYCLES >= (2 ** CNT_WIDTH)) begin : g_bad_timeout
      $error("cdc_hs_tx: TIMEOUT_CYCLES does not fit in CNT_WIDTH bits");
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cdc_hs_tx.sv
// Scoreboard bench for cdc_hs_tx: directed protocol cases plus randomized traffic.
`default_nettype none

module tb_cdc_hs_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          ack_i;
  logic          busy_o;
  logic          timeout_o;
  logic          proto_err_o;
  logic          err_clr_i;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held;
  logic [DW-1:0] popped;
  logic          req_seen;
  int            nxfer;
  logic          dest_en;
  int            dest_fixed;
  int            dest_wait;
  int            acc_cnt;
  int            cyc;
  logic          acc;
  logic [DW-1:0] b2b_words[3];

  always #5 clk = ~clk;

  cdc_hs_tx #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (10),
    .CNT_WIDTH      (16)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .req_o       (req_o),
    .data_o      (data_o),
    .ack_i       (ack_i),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .proto_err_o (proto_err_o),
    .err_clr_i   (err_clr_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n     = 1'b0;
    ack_i      = 1'b0;
    in_valid_i = 1'b0;
    err_clr_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    tick();
  endtask

  // Offer words until the requested number have been accepted.
  task automatic drive_words(input int n, input bit random_mode);
    acc_cnt = 0;
    cyc     = 0;
    while (acc_cnt < n && cyc < 5000) begin
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) acc_cnt++;
      if (random_mode) begin
        in_valid_i = ($urandom_range(0, 9) < 7);
        in_data_i  = DW'($urandom);
      end else if (acc_cnt < n) begin
        in_valid_i = 1'b1;
        in_data_i  = b2b_words[acc_cnt];
      end
    end
    in_valid_i = 1'b0;
    check("stim_accepted", acc_cnt, n);
  endtask

  task automatic drain();
    cyc = 0;
    while ((busy_o || !in_ready_o) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("drain_idle", in_ready_o, 1);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    arst_n     = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    ack_i      = 1'b0;
    err_clr_i  = 1'b0;
    dest_en    = 1'b0;
    dest_fixed = 0;
    dest_wait  = 0;
    req_seen   = 1'b0;
    nxfer      = 0;
    held       = '0;
    b2b_words[0] = 8'h01;
    b2b_words[1] = 8'h02;
    b2b_words[2] = 8'h03;

    fork
      // Scoreboard monitor: each req toggle must present the oldest accepted word.
      forever begin
        @(negedge clk);
        if (!arst_n) begin
          exp_q.delete();
          req_seen = 1'b0;
          nxfer    = 0;
        end else begin
          if (req_o != req_seen) begin
            nxfer++;
            req_seen = req_o;
            if (exp_q.size() == 0) begin
              check("sb_unexpected_req", 1, 0);
            end else begin
              popped = exp_q.pop_front();
              check("sb_data", data_o, popped);
            end
            check("sb_req_parity", req_o, nxfer % 2);
            held = data_o;
          end else if (busy_o) begin
            check("hold_data", data_o, held);
          end
          if (busy_o) check("ready_while_busy", in_ready_o, 0);
          if (in_valid_i && in_ready_o) exp_q.push_back(in_data_i);
        end
      end
      // Destination model: mirror req onto ack after a delay.
      forever begin
        @(posedge clk);
        #1;
        if (dest_en && arst_n && (ack_i != req_o)) begin
          if (dest_wait == 0) begin
            dest_wait = (dest_fixed != 0) ? dest_fixed : int'($urandom_range(1, 6));
          end else begin
            dest_wait--;
            if (dest_wait == 0) ack_i = req_o;
          end
        end else begin
          dest_wait = 0;
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    do_reset();
    check("rst_req", req_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_timeout", timeout_o, 0);
    check("rst_proto", proto_err_o, 0);

    // Basic transfer
    in_valid_i = 1'b1;
    in_data_i  = 8'hA5;
    tick();
    in_valid_i = 1'b0;
    check("basic_data", data_o, 8'hA5);
    check("basic_req", req_o, 1);
    check("basic_busy", busy_o, 1);
    check("basic_ready0", in_ready_o, 0);
    ack_i = 1'b1;
    tick();
    check("basic_ready_c1", in_ready_o, 0);
    tick();
    check("basic_ready_c2", in_ready_o, 0);
    tick();
    check("basic_ready_c3", in_ready_o, 1);
    check("basic_busy_end", busy_o, 0);

    // Back-to-back with a fixed-latency destination
    do_reset();
    dest_en    = 1'b1;
    dest_fixed = 4;
    in_valid_i = 1'b1;
    in_data_i  = b2b_words[0];
    drive_words(3, 1'b0);
    drain();
    check("b2b_req_final", req_o, 1);
    check("b2b_data_final", data_o, 8'h03);

    // Randomized traffic, input data churning while busy
    dest_fixed = 0;
    drive_words(30, 1'b1);
    drain();

    // Timeout
    dest_en    = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = DW'($urandom);
    tick();
    in_valid_i = 1'b0;
    repeat (9) tick();
    check("to_not_yet", timeout_o, 0);
    tick();
    check("to_set", timeout_o, 1);
    check("to_still_busy", busy_o, 1);
    ack_i = ~ack_i;
    repeat (2) tick();
    check("to_late_ack_wait", in_ready_o, 0);
    tick();
    check("to_late_ack_ready", in_ready_o, 1);
    check("to_sticky", timeout_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("to_cleared", timeout_o, 0);

    // Spurious ack while idle
    check("sp_ready_before", in_ready_o, 1);
    ack_i = ~ack_i;
    repeat (2) tick();
    check("sp_ready_blocked", in_ready_o, 0);
    check("sp_proto_early", proto_err_o, 0);
    tick();
    check("sp_proto_set", proto_err_o, 1);
    check("sp_ready_still0", in_ready_o, 0);
    ack_i = ~ack_i;
    repeat (2) tick();
    check("sp_ready_back", in_ready_o, 1);
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("sp_proto_cleared", proto_err_o, 0);

    // Reset while a transfer is in flight
    in_valid_i = 1'b1;
    in_data_i  = 8'h5A;
    tick();
    in_valid_i = 1'b0;
    check("mr_busy_before", busy_o, 1);
    #2;
    arst_n = 1'b0;
    ack_i  = 1'b0;
    #1;
    check("mr_req_async", req_o, 0);
    check("mr_data_async", data_o, 0);
    check("mr_busy_async", busy_o, 0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    tick();
    check("mr_ready_after", in_ready_o, 1);
    check("mr_busy_after", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
